// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared duty-range constants, button FSM state encoding and
//                the saturating target-step helper for the PWM duty control.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Duty is expressed in tenths of the PWM period.
    localparam int DUTY_W = 4;
    localparam logic [DUTY_W-1:0] DUTY_MIN = 4'd1;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd9;
    localparam logic [DUTY_W-1:0] DUTY_RST = 4'd5;

    // Per-button press / hold / auto-repeat state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } btn_state_t;

    // Next target duty for one step request. The range compare happens before
    // the add/subtract, so the result can never wrap past either limit.
    // Simultaneous increase and decrease cancel out.
    function automatic logic [DUTY_W-1:0] duty_step(
        input logic [DUTY_W-1:0] cur,
        input logic              inc,
        input logic              dec
    );
        logic [DUTY_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec && (cur < DUTY_MAX)) begin
            nxt = cur + DUTY_W'(1);
        end else if (dec && !inc && (cur > DUTY_MIN)) begin
            nxt = cur - DUTY_W'(1);
        end
        return nxt;
    endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : One button channel: 2-FF synchroniser, 2-sample debounce
//                history, press/hold/auto-repeat FSM and a one-cycle step.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import pwm_pkg::*;
#(
    parameter int HOLD_W   = 4,
    parameter int RPT_DLY  = 8,
    parameter int RPT_RATE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic samp_en,
    input  logic lockout,
    output logic lvl_nxt,
    output logic step
);

    localparam logic [HOLD_W-1:0] c_dly  = HOLD_W'(RPT_DLY);
    localparam logic [HOLD_W-1:0] c_rate = HOLD_W'(RPT_RATE);

    logic [1:0]        r_sync;
    logic [1:0]        r_hist;
    logic              r_lvl;
    logic [1:0]        w_hist_nxt;
    logic              w_lvl_nxt;
    btn_state_t        r_state;
    btn_state_t        w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_step;
    logic              w_step_nxt;

    // Two-stage synchroniser for the asynchronous button pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
        end
    end

    // Debounced level only moves once two consecutive samples agree; on a
    // sample tick the new level is exposed so the FSM reacts on that tick.
    always_comb begin
        w_hist_nxt = {r_hist[0], r_sync[1]};
        w_lvl_nxt  = r_lvl;
        if (samp_en) begin
            if (w_hist_nxt == 2'b11) begin
                w_lvl_nxt = 1'b1;
            end else if (w_hist_nxt == 2'b00) begin
                w_lvl_nxt = 1'b0;
            end
        end
    end

    // Sample history and debounced level, advanced on each sample tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b00;
            r_lvl  <= 1'b0;
        end else if (samp_en) begin
            r_hist <= w_hist_nxt;
            r_lvl  <= w_lvl_nxt;
        end
    end

    // FSM next state: step on press, after the initial delay, then at the
    // repeat rate. Lockout parks the FSM in IDLE; because IDLE only reacts to
    // a rising level, a button still held after lockout ends stays silent.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_step_nxt  = 1'b0;
        if (samp_en) begin
            if (lockout) begin
                w_state_nxt = IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_lvl_nxt && !r_lvl) begin
                            w_step_nxt  = 1'b1;
                            w_hold_nxt  = c_dly;
                            w_state_nxt = HOLD;
                        end
                    end
                    HOLD, RPT: begin
                        if (!w_lvl_nxt) begin
                            w_state_nxt = IDLE;
                        end else if (r_hold <= HOLD_W'(1)) begin
                            w_step_nxt  = 1'b1;
                            w_hold_nxt  = c_rate;
                            w_state_nxt = RPT;
                        end else begin
                            w_hold_nxt = r_hold - HOLD_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end
        end
    end

    // FSM state, hold counter and registered one-cycle step pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_step  <= w_step_nxt;
        end
    end

    assign lvl_nxt = w_lvl_nxt;
    assign step    = r_step;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_ctrl
//  Description : Button-driven duty controller for the decimal-period PWM.
//                Debounces inc/dec buttons with auto-repeat, keeps a
//                saturating target and commits it only on frame_start.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_ctrl
    import pwm_pkg::*;
#(
    parameter int DEB_DIV  = 4,
    parameter int RPT_DLY  = 8,
    parameter int RPT_RATE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              frame_start,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic              pending,
    output logic              at_max,
    output logic              at_min
);

    localparam int SAMP_W   = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam int HOLD_MAX = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [SAMP_W-1:0] c_samp_last = SAMP_W'(DEB_DIV - 1);

    logic [SAMP_W-1:0] r_samp_cnt;
    logic              w_samp_en;
    logic              w_inc_lvl;
    logic              w_dec_lvl;
    logic              w_lockout;
    logic              w_inc_step;
    logic              w_dec_step;
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] r_duty;
    logic              r_duty_upd;

    // Free-running debounce sample divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp_cnt <= '0;
        end else if (r_samp_cnt == c_samp_last) begin
            r_samp_cnt <= '0;
        end else begin
            r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
        end
    end

    assign w_samp_en = (r_samp_cnt == c_samp_last);

    // Both buttons held together is treated as an invalid chord.
    assign w_lockout = w_inc_lvl & w_dec_lvl;

    btn_debounce #(
        .HOLD_W   (HOLD_W),
        .RPT_DLY  (RPT_DLY),
        .RPT_RATE (RPT_RATE)
    ) u_btn_inc (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_inc),
        .samp_en  (w_samp_en),
        .lockout  (w_lockout),
        .lvl_nxt  (w_inc_lvl),
        .step     (w_inc_step)
    );

    btn_debounce #(
        .HOLD_W   (HOLD_W),
        .RPT_DLY  (RPT_DLY),
        .RPT_RATE (RPT_RATE)
    ) u_btn_dec (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_dec),
        .samp_en  (w_samp_en),
        .lockout  (w_lockout),
        .lvl_nxt  (w_dec_lvl),
        .step     (w_dec_step)
    );

    // Saturating target, updated the cycle after a step pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target <= DUTY_RST;
        end else begin
            r_target <= duty_step(r_target, w_inc_step, w_dec_step);
        end
    end

    // Commit the target on frame boundaries only; a target changing on the
    // same edge is picked up at the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty     <= DUTY_RST;
            r_duty_upd <= 1'b0;
        end else if (frame_start) begin
            r_duty     <= r_target;
            r_duty_upd <= (r_target != r_duty);
        end else begin
            r_duty_upd <= 1'b0;
        end
    end

    assign duty     = r_duty;
    assign duty_upd = r_duty_upd;
    assign pending  = (r_target != r_duty);
    assign at_max   = (r_target == DUTY_MAX);
    assign at_min   = (r_target == DUTY_MIN);

endmodule : pwm_duty_ctrl
`default_nettype wire

// File: tb/tb_pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_duty_ctrl
//  Description : Directed self-checking bench for pwm_duty_ctrl with
//                DEB_DIV=4, RPT_DLY=8, RPT_RATE=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_inc;
    logic       btn_dec;
    logic       frame_start;
    logic [3:0] duty;
    logic       duty_upd;
    logic       pending;
    logic       at_max;
    logic       at_min;

    int n_tests = 0;
    int n_fail  = 0;
    int tnow    = 0;
    int upd_cnt = 0;
    int p;

    always #5 clk = ~clk;

    pwm_duty_ctrl #(
        .DEB_DIV  (4),
        .RPT_DLY  (8),
        .RPT_RATE (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_inc     (btn_inc),
        .btn_dec     (btn_dec),
        .frame_start (frame_start),
        .duty        (duty),
        .duty_upd    (duty_upd),
        .pending     (pending),
        .at_max      (at_max),
        .at_min      (at_min)
    );

    // Running count of duty_upd pulses.
    always @(posedge clk) begin
        if (duty_upd === 1'b1) upd_cnt <= upd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Input changes happen just after a falling edge; tnow counts rising
    // edges since reset release.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            tnow++;
        end
    endtask

    task automatic wait_until(input int t);
        while (tnow < t) tick(1);
    endtask

    task automatic align4();
        while ((tnow % 4) != 0) tick(1);
    endtask

    // One-cycle frame_start; returns with the commit result visible.
    task automatic frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        btn_inc     = 1'b0;
        btn_dec     = 1'b0;
        frame_start = 1'b0;
        tick(3);
        chk("rst_duty",    duty,     5);
        chk("rst_upd",     duty_upd, 0);
        chk("rst_pending", pending,  0);
        chk("rst_at_max",  at_max,   0);
        chk("rst_at_min",  at_min,   0);
        rst  = 1'b0;
        tnow = 0;

        // Idle frames: nothing to commit.
        for (int k = 1; k <= 3; k++) begin
            wait_until(10 * k);
            frame();
            chk("idle_duty", duty,     5);
            chk("idle_upd",  duty_upd, 0);
        end
        chk("idle_upd_cnt", upd_cnt, 0);

        // Short press of 3 samples: exactly one step, 5 -> 6.
        wait_until(32);
        p = tnow;
        btn_inc = 1'b1;
        wait_until(p + 12);
        btn_inc = 1'b0;
        wait_until(p + 24);
        chk("short_pending", pending, 1);
        chk("short_duty_held", duty, 5);
        wait_until(p + 30);
        frame();
        chk("short_duty", duty,     6);
        chk("short_upd",  duty_upd, 1);
        tick(1);
        chk("short_upd_clr", duty_upd, 0);
        chk("short_pend_clr", pending, 0);
        chk("short_upd_cnt", upd_cnt, 1);

        // Long inc hold: 6->7 at press, 8 at +8 samples, 9 at +10, saturate.
        wait_until(p + 40);
        p = tnow;
        btn_inc = 1'b1;
        wait_until(p + 20);
        frame();
        chk("hold_first", duty, 7);
        wait_until(p + 36);
        frame();
        chk("hold_no_early_rpt", duty, 7);
        chk("hold_no_early_upd", duty_upd, 0);
        wait_until(p + 44);
        frame();
        chk("hold_delay_step", duty, 8);
        wait_until(p + 52);
        frame();
        chk("hold_rpt_step", duty, 9);
        chk("hold_at_max", at_max, 1);
        wait_until(p + 62);
        frame();
        chk("hold_sat_duty", duty, 9);
        chk("hold_sat_upd", duty_upd, 0);
        wait_until(p + 75);
        chk("hold_sat_pending", pending, 0);
        chk("hold_sat_at_max", at_max, 1);
        wait_until(p + 80);
        btn_inc = 1'b0;

        // Long dec hold from 9 down to the floor.
        wait_until(p + 100);
        p = tnow;
        btn_dec = 1'b1;
        wait_until(p + 84);
        frame();
        chk("dec_duty2", duty, 2);
        chk("dec_at_min0", at_min, 0);
        wait_until(p + 92);
        frame();
        chk("dec_duty1", duty, 1);
        chk("dec_at_min", at_min, 1);
        wait_until(p + 110);
        frame();
        chk("dec_floor_duty", duty, 1);
        chk("dec_floor_upd", duty_upd, 0);
        chk("dec_floor_pending", pending, 0);
        wait_until(p + 112);
        btn_dec = 1'b0;

        // Both buttons together: no step; inc still held after dec release
        // stays silent until it is pressed again.
        wait_until(p + 132);
        p = tnow;
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        wait_until(p + 40);
        chk("both_pending", pending, 0);
        btn_dec = 1'b0;
        wait_until(p + 44);
        frame();
        chk("both_duty", duty, 1);
        chk("both_upd", duty_upd, 0);
        wait_until(p + 80);
        chk("both_inc_only_pending", pending, 0);
        frame();
        chk("both_inc_only_duty", duty, 1);
        wait_until(p + 82);
        btn_inc = 1'b0;
        wait_until(p + 100);
        p = tnow;
        btn_inc = 1'b1;
        wait_until(p + 12);
        btn_inc = 1'b0;
        wait_until(p + 14);
        chk("rearm_pending", pending, 1);
        wait_until(p + 20);
        frame();
        chk("rearm_duty", duty, 2);
        chk("rearm_upd", duty_upd, 1);

        // Target changes on the same edge as frame_start: deferred a frame.
        tick(4);
        align4();
        p = tnow;
        btn_inc = 1'b1;
        wait_until(p + 8);
        frame();
        chk("same_edge_duty", duty, 2);
        chk("same_edge_upd", duty_upd, 0);
        chk("same_edge_pending", pending, 1);
        wait_until(p + 12);
        btn_inc = 1'b0;
        wait_until(p + 20);
        frame();
        chk("next_frame_duty", duty, 3);
        chk("next_frame_upd", duty_upd, 1);

        // Asynchronous reset in the middle of a hold.
        wait_until(p + 40);
        p = tnow;
        btn_inc = 1'b1;
        wait_until(p + 24);
        chk("pre_rst_pending", pending, 1);
        chk("pre_rst_duty", duty, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_duty", duty, 5);
        chk("async_rst_pending", pending, 0);
        chk("async_rst_upd", duty_upd, 0);
        chk("async_rst_at_max", at_max, 0);
        btn_inc = 1'b0;
        tick(2);
        rst  = 1'b0;
        tnow = 0;
        wait_until(40);
        chk("post_rst_pending", pending, 0);
        frame();
        chk("post_rst_duty", duty, 5);
        chk("post_rst_upd", duty_upd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwm_duty_ctrl
`default_nettype wire

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
- Sequences duty-cycle updates for the decimal-period PWM generator.
- Synchronises and debounces the raw increase and decrease buttons, with auto-repeat on hold.
- Keeps a saturating target duty and commits it to the generator only at a PWM frame boundary, so no glitched or partial PWM periods occur.
- Sits between the top-level ui_in button pins and the PWM counter/comparator.

Parameters:
- DUTY_W, 4, width of the duty value.
- DUTY_MIN, 1, lowest allowed duty (10%).
- DUTY_MAX, 9, highest allowed duty (90%).
- DUTY_RST, 5, duty after reset (50%).
- DEB_DIV, 4, clk cycles per debounce sample (25000000 on FPGA).
- RPT_DLY, 8, debounce samples held before the first auto-repeat.
- RPT_RATE, 2, debounce samples between later auto-repeats.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_inc  in  1  raw increase button, asynchronous.
- btn_dec  in  1  raw decrease button, asynchronous.
- frame_start  in  1  one-cycle pulse from the PWM generator when its counter wraps to 0.
- duty  out  DUTY_W  committed duty fed to the PWM comparator.
- duty_upd  out  1  one-cycle pulse when duty changes value.
- pending  out  1  high while target differs from duty.
- at_max  out  1  target == DUTY_MAX.
- at_min  out  1  target == DUTY_MIN.

Behaviour:
- Reset (async, rst=1):
  - duty = target = DUTY_RST.
  - duty_upd = 0, pending = 0, at_max = 0, at_min = 0.
  - Sample counter, synchronisers, debounce registers and both FSMs cleared to IDLE / level 0.
- Synchronisation: each button passes through a 2-FF synchroniser before any use.
- Sample enable:
  - Counter runs 0..DEB_DIV-1 and wraps.
  - samp_en is high for one cycle when the counter equals DEB_DIV-1.
- Debounce:
  - On samp_en, shift the synchronised level into a 2-bit history.
  - Debounced level goes to 1 when the history is 11 and to 0 when it is 00; otherwise it holds.
- Per-button FSM, advancing only on samp_en:
  - IDLE: on debounced rise, emit step, load hold counter = RPT_DLY, go to HOLD.
  - HOLD: decrement hold counter. At 0, emit step, load RPT_RATE, go to RPT. Debounced low returns to IDLE.
  - RPT: decrement hold counter. At 0, emit step and reload RPT_RATE. Debounced low returns to IDLE.
- Step pulses last one clk cycle.
- Both buttons debounced high: all steps suppressed, both FSMs forced to IDLE, and they re-arm only after release.
- Target update, one cycle after the step:
  - inc step with target < DUTY_MAX: target + 1.
  - dec step with target > DUTY_MIN: target - 1.
  - Otherwise target holds (saturates, no wrap).
- Commit:
  - On frame_start, duty <= target in the same edge.
  - duty_upd pulses in the next cycle if the value changed.
  - A target change in the same cycle as frame_start is not committed; it waits for the next frame.
  - Several steps within one frame collapse; only the final target is committed.
- Combinational flags: pending = (target != duty); at_max and at_min decode target.
- Reset mid-frame or mid-hold: immediate return to reset values. No commit occurs until the next frame_start.
- Widths: all duty arithmetic is DUTY_W bits, with the compare done before the add or subtract, so no overflow is possible.

Decomposition:
- Shared package pwm_pkg holds DUTY_W, DUTY_MIN, DUTY_MAX, DUTY_RST and the 2-bit button-FSM state enum (IDLE, HOLD, RPT).
- Sub-module btn_debounce: synchroniser, debounce history, FSM and step output. Instantiated twice, sharing samp_en.

Test Plan:
- Reset, then frame_start every 10 cycles, no buttons -> duty=5, pending=0, duty_upd never pulses.
- btn_inc high for 3 samples then released (DEB_DIV=4) -> exactly one step, target=6, pending=1 until the next frame_start, then duty=6 and duty_upd pulses once.
- btn_inc held 20 samples -> steps at press, +8 samples, then every 2 samples; target saturates at 9 with at_max=1; duty reaches 9 only at frame boundaries, never beyond.
- btn_dec held from duty=2 -> target 1, at_min=1, further steps ignored, duty never 0.
- Both buttons high together for 10 samples -> no step, target unchanged; releasing dec while inc stays high produces no step until inc is re-pressed.
- Step landing on the same cycle as frame_start -> duty unchanged that frame, committed at the following frame_start. Assert rst mid-HOLD -> duty=5 on the same cycle, FSMs IDLE.
